// File: rtl/sha3_digest_streamer.sv
// Captures the final Keccak state and streams the selected SHA3 digest as
// 16-bit words in canonical (hex-string) byte order with valid/ready/last.
module sha3_digest_streamer #(
    parameter int WIDTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [1:0]               ID,
    input  logic [0:4][0:4][63:0]    Dout,
    input  logic                     hash_valid,
    output logic                     hash_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0][63:0]  lanes;
    logic [1:0]        id_q;
    logic [4:0]        word_cnt;
    logic [4:0]        last_idx;
    logic [63:0]       sel_lane;
    logic [63:0]       shifted;
    logic [WIDTH-1:0]  word_data;
    logic              accept;
    logic              xfer;

    assign accept = hash_valid && (state == IDLE);
    assign xfer   = m_valid && m_ready;

    always_comb begin
        last_idx = 5'd31;
        case (id_q)
            2'd0:    last_idx = 5'd13;
            2'd1:    last_idx = 5'd15;
            2'd2:    last_idx = 5'd23;
            default: last_idx = 5'd31;
        endcase
    end

    // Four words per lane; lanes are little-endian, so word n takes the byte
    // pair at offset 2*(n%4) and puts the lower-addressed byte in the MSBs.
    assign sel_lane  = lanes[word_cnt[4:2]];
    assign shifted   = sel_lane >> {word_cnt[1:0], 4'b0000};
    assign word_data = {shifted[7:0], shifted[15:8]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hash_valid) state_next = STREAM;
            STREAM:  if (xfer && m_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hash_ready = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                hash_ready = 1'b1;
            end
            STREAM: begin
                m_valid = 1'b1;
                busy    = 1'b1;
                m_last  = (word_cnt == last_idx);
                m_data  = word_data;
            end
            default: begin
                hash_ready = 1'b0;
            end
        endcase
    end

    // Only lanes 0..7 in x-major order can hold digest bytes; the rest of
    // the state is never needed once accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            lanes    <= '0;
            id_q     <= 2'd0;
            word_cnt <= 5'd0;
        end else if (accept) begin
            for (int k = 0; k < 8; k++) begin
                lanes[k] <= Dout[k % 5][k / 5];
            end
            id_q     <= ID;
            word_cnt <= 5'd0;
        end else if (xfer && !m_last) begin
            word_cnt <= word_cnt + 5'd1;
        end
    end

endmodule
